// File: rtl/addsub_accum.sv
// -----------------------------------------------------------------------------
// addsub_accum
//   Registered add / subtract / accumulate unit with optional unsigned
//   saturation, status flags and valid/ready handshakes on both sides.
//   One accepted operand beat produces one result beat on the next cycle.
//   A result that is still held can be replaced by a new result on the same
//   edge that it is consumed, so back-to-back beats stream with no bubble.
//
// Parameters
//   WIDTH    operand/result width in bits (>= 2)
//   SAT_EN   1: sat input honoured, 0: results always wrap
//   COUNT_W  width of the accepted-beat counter (wraps silently)
//
// Ports
//   clk        in   clock, all state on the rising edge
//   rst        in   synchronous reset, active-high
//   in_valid   in   operand beat valid
//   in_ready   out  unit can accept a beat this cycle
//   op         in   00 ADD a+b, 01 SUB a-b, 10 ACC acc+a, 11 CLR acc<=a
//   sat        in   unsigned saturation request
//   a, b       in   unsigned operands (b unused by ACC/CLR)
//   out_valid  out  result beat valid
//   out_ready  in   consumer takes the result this cycle
//   result     out  registered result (post-saturation)
//   carry      out  ADD/ACC carry-out, SUB borrow, CLR 0
//   overflow   out  signed overflow of the raw operation, CLR 0
//   zero       out  result == 0
//   acc        out  accumulator value
//   count      out  number of accepted beats
// -----------------------------------------------------------------------------
module addsub_accum #(
  parameter int unsigned WIDTH   = 8,
  parameter bit          SAT_EN  = 1'b1,
  parameter int unsigned COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op,
  input  logic               sat,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               carry,
  output logic               overflow,
  output logic               zero,
  output logic [WIDTH-1:0]   acc,
  output logic [COUNT_W-1:0] count
);

  localparam int unsigned MSB = WIDTH - 1;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ACC = 2'b10,
    OP_CLR = 2'b11
  } op_e;

  // Architectural state
  logic               out_valid_q;
  logic [WIDTH-1:0]   result_q;
  logic               carry_q;
  logic               overflow_q;
  logic               zero_q;
  logic [WIDTH-1:0]   acc_q;
  logic [COUNT_W-1:0] count_q;

  // Next-state values for an accepted beat
  logic [WIDTH-1:0]   result_d;
  logic               carry_d;
  logic               overflow_d;
  logic               zero_d;

  op_e                op_s;
  logic               accept;
  logic               sat_on;
  logic [WIDTH-1:0]   add_l;
  logic [WIDTH-1:0]   add_r;
  logic [WIDTH:0]     sum_w;
  logic [WIDTH:0]     diff_w;
  logic [WIDTH-1:0]   raw;

  assign op_s = op_e'(op);

  // Combinational ready: a held result that is being consumed this cycle
  // frees the output register, so a new beat may enter on the same edge.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign sat_on   = SAT_EN && sat;

  // ADD and ACC share one adder; ACC substitutes the accumulator for a and
  // a for b. Both paths are WIDTH+1 bits so the top bit is carry / borrow.
  assign add_l  = (op_s == OP_ACC) ? acc_q : a;
  assign add_r  = (op_s == OP_ACC) ? a     : b;
  assign sum_w  = {1'b0, add_l} + {1'b0, add_r};
  assign diff_w = {1'b0, a} - {1'b0, b};

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    raw        = sum_w[MSB:0];
    carry_d    = sum_w[WIDTH];
    overflow_d = (add_l[MSB] == add_r[MSB]) && (sum_w[MSB] != add_l[MSB]);
    case (op_s)
      OP_SUB: begin
        raw        = diff_w[MSB:0];
        carry_d    = diff_w[WIDTH];  // borrow out equals (a < b)
        overflow_d = (a[MSB] != b[MSB]) && (diff_w[MSB] != a[MSB]);
      end
      OP_CLR: begin
        raw        = a;
        carry_d    = 1'b0;
        overflow_d = 1'b0;
      end
      default: ;
    endcase

    // Saturation clamps only the result; flags keep reporting the raw op.
    // CLR never sets carry_d, so it is never clamped.
    result_d = raw;
    if (sat_on && carry_d) begin
      result_d = (op_s == OP_SUB) ? '0 : '1;
    end
    zero_d = (result_d == '0);
  end

  // NOTE: state is written with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      acc_q       <= '0;
      count_q     <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      result_q    <= result_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
      count_q     <= count_q + COUNT_W'(1);
      if (op_s == OP_ACC || op_s == OP_CLR) begin
        acc_q <= result_d;
      end
    end else if (out_ready) begin
      // Result consumed with nothing to replace it; data/flags keep last value.
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
  assign acc       = acc_q;
  assign count     = count_q;

endmodule

// File: tb/tb_addsub_accum.sv
// -----------------------------------------------------------------------------
// tb_addsub_accum
//   Drives addsub_accum (WIDTH=8, SAT_EN=1, COUNT_W=8) with directed sequences
//   and randomized traffic. A behavioural model written with plain integer
//   arithmetic tracks every output and is compared one time unit after each
//   rising edge; directed sequences also pin hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_addsub_accum;

  localparam int W    = 8;
  localparam int CW   = 8;
  localparam int MOD  = 2 ** W;
  localparam int HALF = 2 ** (W - 1);
  localparam int CMOD = 2 ** CW;

  localparam int ADD = 0;
  localparam int SUB = 1;
  localparam int ACC = 2;
  localparam int CLR = 3;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    op;
  logic          sat;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          carry;
  logic          overflow;
  logic          zero;
  logic [W-1:0]  acc;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  int m_valid  = 0;
  int m_result = 0;
  int m_carry  = 0;
  int m_ovf    = 0;
  int m_zero   = 0;
  int m_acc    = 0;
  int m_count  = 0;

  addsub_accum #(.WIDTH(W), .SAT_EN(1'b1), .COUNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .sat       (sat),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero),
    .acc       (acc),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic int to_signed(input int v);
    return (v >= HALF) ? v - MOD : v;
  endfunction

  // Result and flags from the arithmetic rules, using unbounded integers.
  task automatic ref_compute(input int opc, input int s, input int x, input int y,
                             input int accv, output int res, output int cy,
                             output int ov);
    int exact;
    int signed_exact;
    case (opc)
      ADD: begin
        exact        = x + y;
        signed_exact = to_signed(x) + to_signed(y);
        cy           = (exact >= MOD) ? 1 : 0;
      end
      SUB: begin
        exact        = x - y;
        signed_exact = to_signed(x) - to_signed(y);
        cy           = (x < y) ? 1 : 0;
      end
      ACC: begin
        exact        = accv + x;
        signed_exact = to_signed(accv) + to_signed(x);
        cy           = (exact >= MOD) ? 1 : 0;
      end
      default: begin
        exact        = x;
        signed_exact = 0;
        cy           = 0;
      end
    endcase
    ov  = (signed_exact < -HALF || signed_exact > HALF - 1) ? 1 : 0;
    res = ((exact % MOD) + MOD) % MOD;
    if (s != 0 && cy != 0) res = (opc == SUB) ? 0 : MOD - 1;
  endtask

  // Model update on each edge, then compare every output.
  always @(posedge clk) begin
    int r, c, v;
    if (rst) begin
      m_valid = 0; m_result = 0; m_carry = 0; m_ovf = 0;
      m_zero = 0; m_acc = 0; m_count = 0;
    end else if (in_valid && (m_valid == 0 || out_ready)) begin
      ref_compute(int'(op), int'(sat), int'(a), int'(b), m_acc, r, c, v);
      m_valid  = 1;
      m_result = r;
      m_carry  = c;
      m_ovf    = v;
      m_zero   = (r == 0) ? 1 : 0;
      if (int'(op) == ACC || int'(op) == CLR) m_acc = r;
      m_count  = (m_count + 1) % CMOD;
    end else if (out_ready) begin
      m_valid = 0;
    end
    #1;
    check("m_out_valid", int'(out_valid), m_valid);
    check("m_in_ready",  int'(in_ready), (m_valid == 0 || out_ready) ? 1 : 0);
    check("m_result",    int'(result),   m_result);
    check("m_carry",     int'(carry),    m_carry);
    check("m_overflow",  int'(overflow), m_ovf);
    check("m_zero",      int'(zero),     m_zero);
    check("m_acc",       int'(acc),      m_acc);
    check("m_count",     int'(count),    m_count);
  end

  task automatic drive(input int opc, input int s, input int x, input int y);
    in_valid = 1'b1;
    op       = 2'(opc);
    sat      = s[0];
    a        = W'(x);
    b        = W'(y);
  endtask

  // One beat presented for a single cycle; returns on the negedge after accept.
  task automatic one_beat(input int opc, input int s, input int x, input int y);
    @(negedge clk);
    drive(opc, s, x, y);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst      = 1'b0;
  endtask

  function automatic int pick_operand();
    case ($urandom_range(0, 7))
      0:       return 0;
      1:       return MOD - 1;
      2:       return HALF;
      3:       return HALF - 1;
      default: return int'($urandom_range(0, MOD - 1));
    endcase
  endfunction

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = 2'b00;
    sat       = 1'b0;
    a         = '0;
    b         = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_result",    int'(result),    0);
    check("rst_acc",       int'(acc),       0);
    check("rst_count",     int'(count),     0);

    // ADD wrap vs saturate
    one_beat(ADD, 0, 200, 100);
    check("add_wrap_result", int'(result),   44);
    check("add_wrap_carry",  int'(carry),    1);
    check("add_wrap_ovf",    int'(overflow), 0);
    check("add_wrap_zero",   int'(zero),     0);
    one_beat(ADD, 1, 200, 100);
    check("add_sat_result",  int'(result),   255);
    check("add_sat_carry",   int'(carry),    1);

    // SUB borrow, wrap vs saturate to zero
    one_beat(SUB, 0, 5, 10);
    check("sub_wrap_result", int'(result), 251);
    check("sub_wrap_carry",  int'(carry),  1);
    one_beat(SUB, 1, 5, 10);
    check("sub_sat_result",  int'(result), 0);
    check("sub_sat_zero",    int'(zero),   1);
    check("sub_sat_carry",   int'(carry),  1);

    // Signed overflow without carry
    one_beat(ADD, 0, 100, 100);
    check("add_ovf_result", int'(result),   200);
    check("add_ovf_carry",  int'(carry),    0);
    check("add_ovf_ovf",    int'(overflow), 1);

    // CLR/ACC/ACC streaming back-to-back
    do_reset();
    @(negedge clk);
    drive(CLR, 0, 10, 0);
    @(negedge clk);
    check("clr_result", int'(result), 10);
    check("clr_valid",  int'(out_valid), 1);
    drive(ACC, 0, 20, 0);
    @(negedge clk);
    check("acc1_result", int'(result), 30);
    check("acc1_valid",  int'(out_valid), 1);
    drive(ACC, 0, 30, 0);
    @(negedge clk);
    in_valid = 1'b0;
    check("acc2_result", int'(result), 60);
    check("acc2_valid",  int'(out_valid), 1);
    check("acc2_acc",    int'(acc), 60);
    check("acc2_count",  int'(count), 3);
    one_beat(ADD, 0, 1, 1);
    check("add_after_acc_result", int'(result), 2);
    check("add_after_acc_acc",    int'(acc), 60);

    // Backpressure: result pending, consumer stalled for 4 cycles
    out_ready = 1'b0;
    drive(ADD, 0, 3, 4);
    repeat (4) begin
      @(negedge clk);
      check("bp_in_ready",  int'(in_ready),  0);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_result",    int'(result),    2);
      check("bp_count",     int'(count),     4);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_release_result", int'(result),    7);
    check("bp_release_valid",  int'(out_valid), 1);
    check("bp_release_count",  int'(count),     5);

    // Reset overrides a pending result and an offered beat
    check("pre_rst_acc",   int'(acc),       60);
    check("pre_rst_valid", int'(out_valid), 1);
    rst = 1'b1;
    drive(ACC, 0, 5, 0);
    @(negedge clk);
    rst = 1'b0;
    check("rst_hit_valid",  int'(out_valid), 0);
    check("rst_hit_acc",    int'(acc),       0);
    check("rst_hit_count",  int'(count),     0);
    check("rst_hit_result", int'(result),    0);
    @(negedge clk);
    in_valid = 1'b0;
    check("post_rst_valid",  int'(out_valid), 1);
    check("post_rst_result", int'(result),    5);
    check("post_rst_acc",    int'(acc),       5);
    check("post_rst_count",  int'(count),     1);

    // Counter wrap: 255 streaming accepts, then one more
    do_reset();
    for (int i = 0; i < CMOD - 1; i++) begin
      @(negedge clk);
      drive(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
            pick_operand(), pick_operand());
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("wrap_count_max", int'(count), CMOD - 1);
    one_beat(CLR, 0, 250, 0);
    check("wrap_count_zero", int'(count), 0);
    check("clr250_acc",      int'(acc),   250);
    one_beat(ACC, 1, 10, 0);
    check("acc_sat_result", int'(result),   255);
    check("acc_sat_carry",  int'(carry),    1);
    check("acc_sat_ovf",    int'(overflow), 0);
    check("acc_sat_acc",    int'(acc),      255);

    // Randomized traffic with random backpressure and occasional reset
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      op        = 2'($urandom_range(0, 3));
      sat       = 1'($urandom_range(0, 1));
      a         = W'(pick_operand());
      b         = W'(pick_operand());
    end
    @(negedge clk);
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
